// File: rtl/sp_pkg.sv
// Shared defaults and pointer type for the stack-pointer step unit.
package sp_pkg;

   localparam int SP_WIDTH = 16;

   typedef logic [15:0] sp_t;

   localparam sp_t SP_BOTTOM_DEF = 16'h0000;
   localparam sp_t SP_TOP_DEF    = 16'hF3FF;
   localparam sp_t SP_RESET_DEF  = 16'hF3FF;

   localparam int WRAP_COUNT_W = 8;

endpackage

// File: rtl/sp_step_comb.sv
// Combinational +1/-1 stack-pointer step with circular wrap inside [SP_BOTTOM, SP_TOP].
module sp_step_comb
   import sp_pkg::*;
#(
   parameter int               WIDTH     = SP_WIDTH,
   parameter logic [WIDTH-1:0] SP_BOTTOM = SP_BOTTOM_DEF,
   parameter logic [WIDTH-1:0] SP_TOP    = SP_TOP_DEF
) (
   input  logic [WIDTH-1:0] SP,
   input  logic             IorD,
   output logic [WIDTH-1:0] newSP,
   output logic             wrapped
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic above_top;
   logic at_or_above_top;
   logic at_or_below_bottom;
   logic below_bottom;

   assign above_top          = SP > SP_TOP;
   assign at_or_above_top    = SP >= SP_TOP;
   assign at_or_below_bottom = SP <= SP_BOTTOM;
   assign below_bottom       = at_or_below_bottom && (SP != SP_BOTTOM);

   // Out-of-window pointers are pulled back to the edge the step is heading away from.
   always_comb begin
      newSP   = SP;
      wrapped = 1'b0;
      if (IorD) begin
         if (at_or_above_top || below_bottom) begin
            newSP   = SP_BOTTOM;
            wrapped = 1'b1;
         end else begin
            newSP = SP + ONE;
         end
      end else begin
         if (above_top || at_or_below_bottom) begin
            newSP   = SP_TOP;
            wrapped = 1'b1;
         end else begin
            newSP = SP - ONE;
         end
      end
   end

endmodule

// File: rtl/sp_adder.sv
// Stack-pointer step unit: combinational next pointer plus a captured copy (sp_q).
// Optional wrap status outputs are enabled with SP_ADDER_WRAP_STATUS_EN.
module sp_adder
   import sp_pkg::*;
#(
   parameter int               WIDTH     = SP_WIDTH,
   parameter logic [WIDTH-1:0] SP_BOTTOM = SP_BOTTOM_DEF,
   parameter logic [WIDTH-1:0] SP_TOP    = SP_TOP_DEF,
   parameter logic [WIDTH-1:0] SP_RESET  = SP_RESET_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] SP,
   input  logic             IorD,
   input  logic             capture,
   output logic [WIDTH-1:0] newSP,
   output logic [WIDTH-1:0] sp_q,
   output logic             wrapped
`ifdef SP_ADDER_WRAP_STATUS_EN
   ,
   output logic                    wrap_sticky,
   output logic [WRAP_COUNT_W-1:0] wrap_count
`endif
);

   generate
      if ((longint'(SP_TOP) <= longint'(SP_BOTTOM)) ||
          (longint'(SP_RESET) < longint'(SP_BOTTOM)) ||
          (longint'(SP_RESET) > longint'(SP_TOP))) begin : g_bad_window
         $error("sp_adder: stack window or reset value is invalid");
      end
   endgenerate

   sp_step_comb #(
      .WIDTH     (WIDTH),
      .SP_BOTTOM (SP_BOTTOM),
      .SP_TOP    (SP_TOP)
   ) u_step (
      .SP      (SP),
      .IorD    (IorD),
      .newSP   (newSP),
      .wrapped (wrapped)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp_q <= SP_RESET;
      end else if (capture) begin
         sp_q <= newSP;
      end
   end

`ifdef SP_ADDER_WRAP_STATUS_EN
   localparam logic [WRAP_COUNT_W-1:0] COUNT_MAX = '1;
   localparam logic [WRAP_COUNT_W-1:0] COUNT_ONE = {{(WRAP_COUNT_W-1){1'b0}}, 1'b1};

   // Only wraps that are actually committed to sp_q are counted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrap_sticky <= 1'b0;
         wrap_count  <= '0;
      end else if (capture && wrapped) begin
         wrap_sticky <= 1'b1;
         if (wrap_count != COUNT_MAX) begin
            wrap_count <= wrap_count + COUNT_ONE;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sp_adder.sv
// Scoreboard bench for sp_adder: directed edge cases plus randomized steps against a window-index model.
module tb_sp_adder;
   import sp_pkg::*;

   localparam sp_t BOT = 16'h0000;
   localparam sp_t TOP = 16'hF3FF;
   localparam sp_t RST = 16'hF3FF;

   logic clk = 1'b0;
   logic reset;
   sp_t  sp;
   logic iord;
   logic capture;
   sp_t  new_sp;
   sp_t  sp_q;
   logic wrapped;
`ifdef SP_ADDER_WRAP_STATUS_EN
   logic       wrap_sticky;
   logic [7:0] wrap_count;
`endif

   sp_adder #(
      .WIDTH     (16),
      .SP_BOTTOM (BOT),
      .SP_TOP    (TOP),
      .SP_RESET  (RST)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .SP          (sp),
      .IorD        (iord),
      .capture     (capture),
      .newSP       (new_sp),
      .sp_q        (sp_q),
      .wrapped     (wrapped)
`ifdef SP_ADDER_WRAP_STATUS_EN
      ,
      .wrap_sticky (wrap_sticky),
      .wrap_count  (wrap_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      sp_t        nsp;
      logic       w;
      sp_t        q;
      logic       sticky;
      logic [7:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   sp_t        m_q;
   logic       m_sticky;
   logic [7:0] m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: position inside the window moves modulo the window size.
   function automatic void ref_step(input sp_t s, input logic inc, output sp_t n, output logic w);
      int size;
      int idx;
      int nidx;
      size = int'(TOP) - int'(BOT) + 1;
      if (int'(s) > int'(TOP)) begin
         n = inc ? BOT : TOP;
         w = 1'b1;
      end else if (int'(s) < int'(BOT)) begin
         n = inc ? BOT : TOP;
         w = 1'b1;
      end else begin
         idx  = int'(s) - int'(BOT);
         nidx = inc ? (idx + 1) % size : (idx + size - 1) % size;
         n    = sp_t'(int'(BOT) + nidx);
         w    = inc ? (idx == size - 1) : (idx == 0);
      end
   endfunction

   task automatic push_and_advance(input logic cap, input sp_t en, input logic ew);
      exp_t e;
      e.nsp    = en;
      e.w      = ew;
      e.q      = m_q;
      e.sticky = m_sticky;
      e.cnt    = m_cnt;
      sb.push_back(e);
      if (cap) begin
         m_q = en;
         if (ew) begin
            m_sticky = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
         end
      end
   endtask

   task automatic drive_exp(input sp_t s, input logic inc, input logic cap, input sp_t en, input logic ew);
      @(posedge clk);
      #1;
      sp      = s;
      iord    = inc;
      capture = cap;
      push_and_advance(cap, en, ew);
   endtask

   task automatic drive_rand(input sp_t s, input logic inc, input logic cap);
      sp_t  n;
      logic w;
      ref_step(s, inc, n, w);
      drive_exp(s, inc, cap, n, w);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("newSP",   32'(new_sp),  32'(e.nsp));
            chk("wrapped", 32'(wrapped), 32'(e.w));
            chk("sp_q",    32'(sp_q),    32'(e.q));
`ifdef SP_ADDER_WRAP_STATUS_EN
            chk("wrap_sticky", 32'(wrap_sticky), 32'(e.sticky));
            chk("wrap_count",  32'(wrap_count),  32'(e.cnt));
`endif
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      sp_t edges [6];
      sp_t s;
      edges = '{16'h0000, 16'h0001, 16'hF3FE, 16'hF3FF, 16'hF400, 16'hFFFF};

      reset    = 1'b1;
      sp       = '0;
      iord     = 1'b0;
      capture  = 1'b0;
      m_q      = RST;
      m_sticky = 1'b0;
      m_cnt    = 8'd0;
      #1;
      chk("sp_q_at_reset", 32'(sp_q), 32'(RST));
`ifdef SP_ADDER_WRAP_STATUS_EN
      chk("sticky_at_reset", 32'(wrap_sticky), 32'd0);
      chk("count_at_reset",  32'(wrap_count),  32'd0);
`endif
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      drive_exp(16'h0006, 1'b1, 1'b0, 16'h0007, 1'b0);
      drive_exp(16'h0000, 1'b0, 1'b0, 16'hF3FF, 1'b1);
      drive_exp(16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0);
      drive_exp(16'hF3FF, 1'b1, 1'b0, 16'h0000, 1'b1);
      drive_exp(16'hFFF0, 1'b0, 1'b0, 16'hF3FF, 1'b1);
      drive_exp(16'hFFF0, 1'b1, 1'b0, 16'h0000, 1'b1);
      drive_exp(16'h0010, 1'b0, 1'b1, 16'h000F, 1'b0);
      drive_exp(16'h0020, 1'b1, 1'b0, 16'h0021, 1'b0);
      drive_exp(16'h0020, 1'b1, 1'b0, 16'h0021, 1'b0);

      drive_exp(16'hF3FF, 1'b1, 1'b1, 16'h0000, 1'b1);
      drive_exp(16'h0000, 1'b0, 1'b1, 16'hF3FF, 1'b1);
      drive_exp(16'hFFF0, 1'b1, 1'b1, 16'h0000, 1'b1);
      drive_exp(16'h0005, 1'b1, 1'b0, 16'h0006, 1'b0);
      drive_exp(16'h0005, 1'b1, 1'b0, 16'h0006, 1'b0);

      // Asynchronous reset in the middle of a low clock phase.
      @(negedge clk);
      #2;
      reset   = 1'b1;
      sp      = 16'h0010;
      iord    = 1'b0;
      capture = 1'b1;
      #1;
      chk("sp_q_async_reset", 32'(sp_q), 32'(RST));
`ifdef SP_ADDER_WRAP_STATUS_EN
      chk("sticky_cleared", 32'(wrap_sticky), 32'd0);
      chk("count_cleared",  32'(wrap_count),  32'd0);
`endif
      m_q      = RST;
      m_sticky = 1'b0;
      m_cnt    = 8'd0;

      // Reset still asserted at this edge while capture is high: reset must win.
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("sp_q_reset_wins", 32'(sp_q), 32'(RST));
      m_q = 16'h000F;

      drive_exp(16'h0010, 1'b0, 1'b0, 16'h000F, 1'b0);
      drive_exp(16'h1234, 1'b1, 1'b0, 16'h1235, 1'b0);
      drive_exp(16'h1234, 1'b1, 1'b0, 16'h1235, 1'b0);

      repeat (300) drive_exp(16'h0000, 1'b0, 1'b1, 16'hF3FF, 1'b1);
      drive_exp(16'h0003, 1'b0, 1'b0, 16'h0002, 1'b0);
      drive_exp(16'h0003, 1'b0, 1'b0, 16'h0002, 1'b0);

      repeat (400) begin
         case ($urandom_range(0, 2))
            0:       s = sp_t'($urandom);
            1:       s = edges[$urandom_range(0, 5)];
            default: s = sp_t'($urandom_range(int'(BOT), int'(TOP)));
         endcase
         drive_rand(s, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      end
      drive_rand(16'h0100, 1'b1, 1'b0);

      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
